// File: rtl/argmax_classifier.sv
// Sequential argmax over NUM_CLASSES signed neuron scores: one comparison per cycle, valid/ready result.
// Optional second-largest tracking and margin output when ARGMAX_MARGIN_EN is defined.
module argmax_classifier #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_W     = 26
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
  input  logic                           scores_valid,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [3:0]                     class_id,
  output logic [SCORE_W-1:0]             max_score,
`ifdef ARGMAX_MARGIN_EN
  output logic [SCORE_W:0]               margin,
`endif
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned IW = $clog2(NUM_CLASSES + 1);
  localparam int unsigned CW = $clog2(NUM_CLASSES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state, state_next;
  logic signed [SCORE_W-1:0] sc [NUM_CLASSES];
  logic signed [SCORE_W-1:0] best;
  logic signed [SCORE_W-1:0] cur;
  logic [3:0]                best_idx;
  logic [IW-1:0]             idx;
  logic                      accept;
  logic                      last;
  logic                      replace;
`ifdef ARGMAX_MARGIN_EN
  logic signed [SCORE_W-1:0] second;
`endif

  always_comb begin
    accept     = scores_valid && ((state == IDLE) || ((state == DONE) && out_ready));
    // idx == NUM_CLASSES is a finalise cycle that makes the result land NUM_CLASSES edges after capture
    last       = (idx == IW'(NUM_CLASSES));
    cur        = sc[idx[CW-1:0]];
    replace    = (state == SCAN) && !last && (cur > best);
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = accept ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) sc[k] <= '0;
      best      <= '0;
      best_idx  <= '0;
      idx       <= '0;
      class_id  <= '0;
      max_score <= '0;
      overrun   <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second    <= '0;
      margin    <= '0;
`endif
    end else begin
      if (scores_valid && !accept) overrun <= 1'b1;
      if (accept) begin
        for (int unsigned k = 0; k < NUM_CLASSES; k++) sc[k] <= scores[k*SCORE_W +: SCORE_W];
        best     <= scores[SCORE_W-1:0];
        best_idx <= '0;
        idx      <= IW'(1);
`ifdef ARGMAX_MARGIN_EN
        second   <= {1'b1, {(SCORE_W-1){1'b0}}};
`endif
      end else if (state == SCAN) begin
        if (last) begin
          class_id  <= best_idx;
          max_score <= best;
`ifdef ARGMAX_MARGIN_EN
          margin    <= {best[SCORE_W-1], best} - {second[SCORE_W-1], second};
`endif
        end else begin
          idx <= idx + IW'(1);
          if (replace) begin
            best     <= cur;
            best_idx <= 4'(idx);
`ifdef ARGMAX_MARGIN_EN
            second   <= best;
`endif
          end
`ifdef ARGMAX_MARGIN_EN
          else if (cur > second) second <= cur;
`endif
        end
      end
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed scoreboard bench for argmax_classifier; margin checks are active when ARGMAX_MARGIN_EN is defined.
module tb_argmax_classifier;

  localparam int N = 10;
  localparam int W = 26;

  typedef logic signed [W-1:0] sc_t;
  typedef struct {
    logic [3:0] id;
    logic [W-1:0] mx;
    logic [W:0] mg;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] scores;
  logic           scores_valid;
  logic           out_ready;
  logic           out_valid;
  logic [3:0]     class_id;
  logic [W-1:0]   max_score;
`ifdef ARGMAX_MARGIN_EN
  logic [W:0]     margin;
`endif
  logic           busy;
  logic           overrun;

  argmax_classifier #(.NUM_CLASSES(N), .SCORE_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .scores(scores),
    .scores_valid(scores_valid),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .class_id(class_id),
    .max_score(max_score),
`ifdef ARGMAX_MARGIN_EN
    .margin(margin),
`endif
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc++;

  int   vectors = 0;
  int   fails = 0;
  int   cyc_cap = 0;
  int   lat = 0;
  sc_t  v [N];
  exp_t q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first-occurrence maximum; second-largest taken over all other indices.
  function automatic exp_t model();
    exp_t e;
    sc_t  best;
    sc_t  second;
    int   bi;
    best = v[0];
    bi = 0;
    for (int k = 1; k < N; k++) if (v[k] > best) begin best = v[k]; bi = k; end
    second = {1'b1, {(W-1){1'b0}}};
    for (int k = 0; k < N; k++) if (k != bi && v[k] > second) second = v[k];
    e.id = 4'(bi);
    e.mx = best;
    e.mg = {best[W-1], best} - {second[W-1], second};
    return e;
  endfunction

  task automatic send(input bit push);
    for (int k = 0; k < N; k++) scores[k*W +: W] = v[k];
    scores_valid = 1'b1;
    @(posedge clk);
    #1;
    scores_valid = 1'b0;
    if (push) begin
      q.push_back(model());
      cyc_cap = cyc;
    end
    for (int k = 0; k < N; k++) scores[k*W +: W] = W'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 40 && out_valid !== 1'b1; n++) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - cyc_cap;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input bit do_lat);
    exp_t e;
    check({tag, "_sb"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      if (do_lat) check({tag, "_latency"}, 32'(lat), 32'(N));
      check({tag, "_class_id"}, 32'(class_id), 32'(e.id));
      check({tag, "_max_score"}, 32'(max_score), 32'(e.mx));
`ifdef ARGMAX_MARGIN_EN
      check({tag, "_margin"}, 32'(margin), 32'(e.mg));
`endif
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_class_id"}, 32'(class_id), 32'd0);
    check({tag, "_max_score"}, 32'(max_score), 32'd0);
`ifdef ARGMAX_MARGIN_EN
    check({tag, "_margin"}, 32'(margin), 32'd0);
`endif
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check({tag, "_no_valid"}, 32'(seen), 32'd0);
  endtask

  task automatic rand_set();
    for (int k = 0; k < N; k++) v[k] = sc_t'(int'($urandom_range(0, 2097152)) - 1048576);
  endtask

  initial begin
    rst = 1'b1;
    scores = '0;
    scores_valid = 1'b0;
    out_ready = 1'b1;
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ascending scores: last class wins
    for (int k = 0; k < N; k++) v[k] = sc_t'(k * 100);
    send(1'b1);
    wait_valid("asc");
    check_result("asc", 1'b1);
    @(posedge clk);
    #1;
    check("asc_idle_valid", 32'(out_valid), 32'd0);
    check("asc_idle_busy", 32'(busy), 32'd0);
    check("asc_retain_id", 32'(class_id), 32'd9);

    // All negative: signed compare must pick -5
    for (int k = 0; k < N; k++) v[k] = sc_t'(-50 - k * 7);
    v[3] = -5;
    v[9] = {1'b1, {(W-1){1'b0}}};
    send(1'b1);
    wait_valid("neg");
    check_result("neg", 1'b1);
    check("neg_id", 32'(class_id), 32'd3);
    @(posedge clk);
    #1;

    // Tie: lower index kept, zero margin
    for (int k = 0; k < N; k++) v[k] = '0;
    v[2] = 1000;
    v[7] = 1000;
    send(1'b1);
    wait_valid("tie");
    check_result("tie", 1'b1);
    check("tie_id", 32'(class_id), 32'd2);
    @(posedge clk);
    #1;

    // Backpressure with a dropped set arriving during DONE
    out_ready = 1'b0;
    rand_set();
    send(1'b1);
    wait_valid("hold");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        rand_set();
        v[5] = sc_t'(1 << 24);
        send(1'b0);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_overrun", 32'(overrun), 32'd1);
    check_result("hold", 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release", 32'(out_valid), 32'd0);
    watch_quiet("hold_drop", 15);

    // Reset in the middle of a scan
    rand_set();
    send(1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #3;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    watch_quiet("midrst", 20);
    rand_set();
    send(1'b1);
    wait_valid("postrst");
    check_result("postrst", 1'b1);
    @(posedge clk);
    #1;

    // Handshake and new capture on the same DONE cycle
    out_ready = 1'b0;
    rand_set();
    send(1'b1);
    wait_valid("b2b_a");
    check_result("b2b_a", 1'b1);
    out_ready = 1'b1;
    rand_set();
    v[8] = sc_t'(1 << 23);
    send(1'b1);
    check("b2b_gap_valid", 32'(out_valid), 32'd0);
    check("b2b_gap_busy", 32'(busy), 32'd1);
    wait_valid("b2b_b");
    check_result("b2b_b", 1'b1);
    check("b2b_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter: NUM_CLASSES, 10, number of neuron scores compared (2..16).
REQ-002 Parameter: SCORE_W, 26, neuron score width, two's-complement fixed point.
REQ-003 Port: clk  input  1  clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: scores  input  NUM_CLASSES*SCORE_W  packed neuron outputs; class k at bits [k*SCORE_W +: SCORE_W].
REQ-006 Port: scores_valid  input  1  single-cycle strobe, all neuron Output_Valid ANDed upstream.
REQ-007 Port: out_ready  input  1  consumer accepts result.
REQ-008 Port: out_valid  output  1  result valid, held until accepted.
REQ-009 Port: class_id  output  4  index of largest score.
REQ-010 Port: max_score  output  SCORE_W  value of largest score.
REQ-011 Port: busy  output  1  high in SCAN or DONE.
REQ-012 Port: overrun  output  1  sticky, scores_valid arrived while not accepting.
REQ-013 Port: margin  output  SCORE_W+1  max minus second-largest, unsigned; present only per REQ-027.

Function
REQ-014 FSM states IDLE, SCAN, DONE; IDLE after reset.
REQ-015 IDLE, scores_valid=1: register all scores, best=score[0], best_idx=0, idx=1, go SCAN.
REQ-016 SCAN: one comparison per cycle, score[idx] vs best, signed compare; idx increments each cycle.
REQ-017 Replace best/best_idx only if score[idx] strictly greater; ties keep lower index.
REQ-018 After comparing idx=NUM_CLASSES-1, go DONE; out_valid rises NUM_CLASSES edges after the capturing edge (10 for default).
REQ-019 DONE: out_valid=1, class_id/max_score stable until the edge where out_valid&&out_ready.
REQ-020 Handshake with scores_valid=0: go IDLE, out_valid=0 next cycle.
REQ-021 Handshake with scores_valid=1 same cycle: capture new scores, go directly SCAN, no bubble, no overrun.
REQ-022 scores_valid in SCAN, or in DONE without handshake: input dropped, overrun set to 1; result in progress unaffected.
REQ-023 Input scores sampled only at capture; later changes on scores have no effect.
REQ-024 class_id, max_score retain last result in IDLE; updated only at DONE entry.

Reset
REQ-025 rst asserted: state=IDLE, out_valid=0, busy=0, overrun=0, class_id=0, max_score=0, margin=0, internal registers 0, immediately, no clock needed.
REQ-026 rst mid-SCAN or in DONE: result discarded, no out_valid pulse after release; first scores_valid after release accepted normally.

Configuration
REQ-027 Macro ARGMAX_MARGIN_EN defined: second-largest tracked in SCAN (on replace, old best becomes second; else second=max(second,score[idx])); margin=best-second, SCORE_W+1 bits, valid with out_valid; ties give margin 0.
REQ-028 ARGMAX_MARGIN_EN undefined: no second-largest logic, margin port absent; all other behaviour and latency identical.

Verification
REQ-029 scores k*100 (k=0..9), pulse scores_valid, out_ready=1 -> out_valid 10 edges later, class_id=9, max_score=900, margin=100.
REQ-030 All scores negative, score[3]=-5 largest, others <=-50 -> class_id=3, max_score=-5 (signed compare, not unsigned).
REQ-031 score[2]=score[7]=1000, others 0 -> class_id=2, margin=0.
REQ-032 out_ready=0 for 20 cycles after DONE, new scores_valid at cycle 5 of wait -> result held, overrun=1, dropped set never reported.
REQ-033 out_ready=1 and scores_valid=1 same DONE cycle -> second result 10 edges later, overrun=0, both results correct.
REQ-034 rst pulsed at SCAN cycle 4 -> out_valid never asserted for that set, all outputs 0, next set classified correctly.
